// File: rtl/line_mem_responder_if.sv
// ---------------------------------------------------------------------------
// line_mem_responder_if
//
// Line-memory request/response bus between a cache (master) and the line
// memory responder (slave).
//
// Handshake: a request is level-signalled by DDATA_ren / DDATA_wen together
// with DDATA_addr and DDATA_wdata. The responder samples the request only
// while it is idle. It ignores any later change to the request until it
// pulses DDATA_ready high for exactly one cycle to complete it. A request
// still asserted in the cycle after DDATA_ready is taken as a new request, so
// the master drops its request by then unless it wants another. If both
// DDATA_ren and DDATA_wen are high, the request is a write.
//
// Signals:
//   DDATA_ren    master->slave  line read request
//   DDATA_wen    master->slave  line write request
//   DDATA_addr   master->slave  27-bit line address (low 9 bits used)
//   DDATA_wdata  master->slave  256-bit write line
//   DDATA_rdata  slave->master  256-bit registered read line
//   DDATA_ready  slave->master  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface line_mem_responder_if;
    logic         DDATA_ren;
    logic         DDATA_wen;
    logic [26:0]  DDATA_addr;
    logic [255:0] DDATA_wdata;
    logic [255:0] DDATA_rdata;
    logic         DDATA_ready;

    modport master (
        output DDATA_ren,
        output DDATA_wen,
        output DDATA_addr,
        output DDATA_wdata,
        input  DDATA_rdata,
        input  DDATA_ready
    );

    modport slave (
        input  DDATA_ren,
        input  DDATA_wen,
        input  DDATA_addr,
        input  DDATA_wdata,
        output DDATA_rdata,
        output DDATA_ready
    );
endinterface

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
//
// Fixed-latency 256-bit line memory model that answers cache line reads and
// writes. The block accepts a request in IDLE and counts LATENCY cycles. It
// then commits or reads the line on entry to DONE and pulses DDATA_ready for
// one cycle.
//
// Parameters:
//   LATENCY  cycles from the accepting edge to DDATA_ready (1..255)
//   DEPTH    number of 256-bit lines (<= 512); indices wrap modulo DEPTH
//
// Ports:
//   clk_i      clock, rising edge
//   start_i    asynchronous active-low reset
//   bus        line_mem_responder_if.slave (request/response bus)
//   rd_cnt     16-bit saturating count of completed reads  (stats build only)
//   wr_cnt     16-bit saturating count of completed writes (stats build only)
//   dbg_state  current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Optional feature: define LINE_MEM_RESP_STATS_EN to add rd_cnt / wr_cnt.
// The line array itself is never reset.
// ---------------------------------------------------------------------------
module line_mem_responder #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic                  clk_i,
    input  logic                  start_i,
    line_mem_responder_if.slave   bus,
`ifdef LINE_MEM_RESP_STATS_EN
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt,
`endif
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t       state;
    state_t       state_next;
    logic [7:0]   cnt;
    logic         req_wr;
    logic [8:0]   req_addr;
    logic [255:0] req_wdata;
    logic [255:0] rdata_q;

    logic [255:0] mem [DEPTH];

    logic         req_any;
    logic         accept;
    logic         enter_done;
    logic         commit_wr;
    logic [8:0]   commit_addr;
    logic [255:0] commit_wdata;
    logic [AW-1:0] commit_idx;
    logic         addr_hi_unused;

    assign req_any        = bus.DDATA_ren | bus.DDATA_wen;
    assign addr_hi_unused = ^bus.DDATA_addr[26:9];

    // Next-state logic
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    accept     = 1'b1;
                    state_next = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 8'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_done = (state_next == DONE);

    // With LATENCY=1 the request goes straight from IDLE to DONE. The latch
    // registers are not yet loaded on that edge, so the commit takes the live
    // request instead.
    always_comb begin
        commit_wr    = req_wr;
        commit_addr  = req_addr;
        commit_wdata = req_wdata;
        if (state == IDLE) begin
            commit_wr    = bus.DDATA_wen;
            commit_addr  = bus.DDATA_addr[8:0];
            commit_wdata = bus.DDATA_wdata;
        end
        commit_idx = AW'(32'(commit_addr) % 32'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            req_wr    <= 1'b0;
            req_addr  <= 9'd0;
            req_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_wr    <= bus.DDATA_wen;
                req_addr  <= bus.DDATA_addr[8:0];
                req_wdata <= bus.DDATA_wdata;
                cnt       <= CNT_LOAD;
            end else if (state == BUSY) begin
                cnt <= cnt - 8'd1;
            end
            // Read data only changes on completion of a read.
            if (enter_done && !commit_wr) begin
                rdata_q <= mem[commit_idx];
            end
        end
    end

    // The array is not reset. start_i gates the write so that an edge taken
    // while held in reset can never commit a line.
    always_ff @(posedge clk_i) begin
        if (start_i && enter_done && commit_wr) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    assign bus.DDATA_rdata = rdata_q;
    assign bus.DDATA_ready = (state == DONE);
    assign dbg_state       = state;

`ifdef LINE_MEM_RESP_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // One increment per DONE cycle; the latched op is valid in DONE for every
    // latency, including the direct IDLE->DONE path.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (state == DONE) begin
            if (req_wr) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_line_mem_responder
//
// Bench for line_mem_responder with two instances. u0 uses LATENCY=10 and
// DEPTH=512; u1 uses LATENCY=1 and DEPTH=256 for back-to-back and wrap cases.
// Drivers push the expected read line and ready cycle into per-instance
// queues. A monitor per instance pops and compares on every DDATA_ready.
// ---------------------------------------------------------------------------
module tb_line_mem_responder;

    localparam int LAT0   = 10;
    localparam int DEPTH0 = 512;
    localparam int LAT1   = 1;
    localparam int DEPTH1 = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic start_i;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    line_mem_responder_if bus0 ();
    line_mem_responder_if bus1 ();
    logic [1:0] dbg0;
    logic [1:0] dbg1;
`ifdef LINE_MEM_RESP_STATS_EN
    logic [15:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;
`endif

    line_mem_responder #(.LATENCY(LAT0), .DEPTH(DEPTH0)) u0 (
        .clk_i     (clk),
        .start_i   (start_i),
        .bus       (bus0.slave),
`ifdef LINE_MEM_RESP_STATS_EN
        .rd_cnt    (rd_cnt0),
        .wr_cnt    (wr_cnt0),
`endif
        .dbg_state (dbg0)
    );

    line_mem_responder #(.LATENCY(LAT1), .DEPTH(DEPTH1)) u1 (
        .clk_i     (clk),
        .start_i   (start_i),
        .bus       (bus1.slave),
`ifdef LINE_MEM_RESP_STATS_EN
        .rd_cnt    (rd_cnt1),
        .wr_cnt    (wr_cnt1),
`endif
        .dbg_state (dbg1)
    );

    // ---------------- scoreboard ----------------
    logic [255:0] exp0_q[$];
    int           exp0_cyc_q[$];
    logic [255:0] exp1_q[$];
    int           exp1_cyc_q[$];
    logic [255:0] model0 [DEPTH0];
    logic [255:0] model1 [DEPTH1];
    logic [255:0] last_rd0;
    int           rd_m;
    int           wr_m;
    int           done0 = 0;
    int           checks = 0;
    int           errors = 0;
    logic [255:0] e0, e1;
    int           ec0, ec1;

    function automatic logic [255:0] pat(input int i);
        return {8{32'hA000_0000 | 32'(i)}};
    endfunction

    function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (start_i && bus0.DDATA_ready) begin
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ready0_unexpected: got ready=1 at cycle %0d expected no ready", cyc);
            end else begin
                e0  = exp0_q.pop_front();
                ec0 = exp0_cyc_q.pop_front();
                chk("ready0_cycle", 256'(cyc), 256'(ec0));
                chk("rdata0", bus0.DDATA_rdata, e0);
                done0++;
            end
        end
    end

    always @(negedge clk) begin
        if (start_i && bus1.DDATA_ready) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ready1_unexpected: got ready=1 at cycle %0d expected no ready", cyc);
            end else begin
                e1  = exp1_q.pop_front();
                ec1 = exp1_cyc_q.pop_front();
                chk("ready1_cycle", 256'(cyc), 256'(ec1));
                chk("rdata1", bus1.DDATA_rdata, e1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle0();
        for (int k = 0; k < 50 && dbg0 != 2'd0; k++) @(negedge clk);
    endtask

    task automatic do_req0(input bit rd, input bit wr, input logic [26:0] addr,
                           input logic [255:0] wdata);
        int           acc;
        int           idx;
        int           target;
        logic [255:0] e;
        wait_idle0();
        idx = int'(addr[8:0]);
        if (wr) begin
            model0[idx] = wdata;
            e           = last_rd0;
            wr_m++;
        end else begin
            e        = model0[idx];
            last_rd0 = e;
            rd_m++;
        end
        target            = done0 + 1;
        bus0.DDATA_ren    = rd;
        bus0.DDATA_wen    = wr;
        bus0.DDATA_addr   = addr;
        bus0.DDATA_wdata  = wdata;
        @(posedge clk);
        #1;
        acc = cyc;
        exp0_q.push_back(e);
        exp0_cyc_q.push_back(acc + LAT0 - 1);
        @(negedge clk);
        // Scramble the idle request lines while the responder is busy.
        bus0.DDATA_ren   = 1'b0;
        bus0.DDATA_wen   = 1'b0;
        bus0.DDATA_addr  = 27'($urandom);
        bus0.DDATA_wdata = ~wdata;
        for (int k = 0; k < 400; k++) begin
            if (done0 >= target) break;
            @(negedge clk);
        end
        if (done0 < target) begin
            checks++;
            errors++;
            $display("FAIL timeout0: got no ready after 400 cycles expected ready for addr %h", addr);
            exp0_q.delete();
            exp0_cyc_q.delete();
        end
    endtask

    task automatic abort_write0();
        wait_idle0();
        bus0.DDATA_wen   = 1'b1;
        bus0.DDATA_ren   = 1'b0;
        bus0.DDATA_addr  = 27'h3;
        bus0.DDATA_wdata = 256'hF;
        @(posedge clk);
        @(negedge clk);
        bus0.DDATA_wen = 1'b0;
        repeat (3) @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("abort_ready", 256'(bus0.DDATA_ready), 256'(0));
        chk("abort_state", 256'(dbg0), 256'(0));
        chk("abort_rdata", bus0.DDATA_rdata, 256'h0);
        last_rd0 = '0;
        rd_m     = 0;
        wr_m     = 0;
        repeat (2) @(negedge clk);
        chk("abort_ready_held", 256'(bus0.DDATA_ready), 256'(0));
        start_i = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic stream1();
        int           c0;
        logic [26:0]  a;
        c0 = cyc;
        for (int j = 0; j < 10; j++) begin
            a = 27'(200 + j * 59) | 27'h0400_000;
            if ((j % 2) == 0) begin
                exp1_q.push_back(model1[int'(a[8:0]) % DEPTH1]);
                exp1_cyc_q.push_back(c0 + j + LAT1);
            end
            bus1.DDATA_ren   = 1'b1;
            bus1.DDATA_addr  = a;
            bus1.DDATA_wdata = 256'(j);
            @(negedge clk);
        end
        bus1.DDATA_ren = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        start_i          = 1'b0;
        bus0.DDATA_ren   = 1'b0;
        bus0.DDATA_wen   = 1'b0;
        bus0.DDATA_addr  = '0;
        bus0.DDATA_wdata = '0;
        bus1.DDATA_ren   = 1'b0;
        bus1.DDATA_wen   = 1'b0;
        bus1.DDATA_addr  = '0;
        bus1.DDATA_wdata = '0;
        last_rd0         = '0;
        rd_m             = 0;
        wr_m             = 0;
        #1;
        for (int i = 0; i < DEPTH0; i++) begin
            model0[i]  = pat(i);
            u0.mem[i]  = pat(i);
        end
        model0[0] = 256'h5;
        u0.mem[0] = 256'h5;
        for (int i = 0; i < DEPTH1; i++) begin
            model1[i] = pat(i + 1000);
            u1.mem[i] = pat(i + 1000);
        end

        repeat (3) @(negedge clk);
        chk("reset_ready", 256'(bus0.DDATA_ready), 256'(0));
        chk("reset_rdata", bus0.DDATA_rdata, 256'h0);
        chk("reset_state", 256'(dbg0), 256'(0));
`ifdef LINE_MEM_RESP_STATS_EN
        chk("reset_rd_cnt", 256'(rd_cnt0), 256'(0));
        chk("reset_wr_cnt", 256'(wr_cnt0), 256'(0));
`endif
        start_i = 1'b1;
        @(negedge clk);

        do_req0(1'b1, 1'b0, 27'h0,     256'h0);
        do_req0(1'b0, 1'b1, 27'h23,    {32{8'hA5}});
        do_req0(1'b1, 1'b0, 27'h23,    256'h0);
        do_req0(1'b1, 1'b0, 27'hA23,   256'h0);
        do_req0(1'b1, 1'b1, 27'h7,     256'h1);
        do_req0(1'b1, 1'b0, 27'h7,     256'h0);

        abort_write0();
        do_req0(1'b1, 1'b0, 27'h3,     256'h0);
        do_req0(1'b1, 1'b0, 27'h23,    256'h0);
        do_req0(1'b0, 1'b1, 27'h10,    256'hDEAD_BEEF);
        do_req0(1'b0, 1'b1, 27'h1FF,   {8{32'h1234_5678}});
        do_req0(1'b1, 1'b0, 27'h1FF,   256'h0);
        repeat (2) @(negedge clk);
`ifdef LINE_MEM_RESP_STATS_EN
        chk("stats_rd_cnt", 256'(rd_cnt0), 256'(rd_m));
        chk("stats_wr_cnt", 256'(wr_cnt0), 256'(wr_m));
        wait_idle0();
        u0.wr_cnt_q = 16'hFFFF;
        do_req0(1'b0, 1'b1, 27'h11, 256'h77);
        repeat (2) @(negedge clk);
        chk("stats_wr_sat", 256'(wr_cnt0), 256'hFFFF);
        chk("stats_rd_after_sat", 256'(rd_cnt0), 256'(rd_m));
`endif

        stream1();

        for (int k = 0; k < 100 && (exp0_q.size() != 0 || exp1_q.size() != 0); k++)
            @(negedge clk);
        chk("pending0", 256'(exp0_q.size()), 256'(0));
        chk("pending1", 256'(exp1_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 Parameter LATENCY, default 10, gives the cycles from request acceptance to DDATA_ready; legal range 1..255.
REQ-002 Parameter DEPTH, default 512, gives the number of 256-bit lines held.
REQ-003 Port clk_i, input, 1 bit, single clock; all state updates on the rising edge.
REQ-004 Port start_i, input, 1 bit, asynchronous active-low reset: low resets, high runs.
REQ-005 Port DDATA_ren, input, 1 bit, line read request from the cache.
REQ-006 Port DDATA_wen, input, 1 bit, line write request from the cache.
REQ-007 Port DDATA_addr, input, 27 bits, line address; bits [8:0] index the array and bits [26:9] are ignored.
REQ-008 Port DDATA_wdata, input, 256 bits, write line data.
REQ-009 Port DDATA_rdata, output, 256 bits, registered read line data.
REQ-010 Port DDATA_ready, output, 1 bit, one-cycle completion pulse for the accepted request.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, BUSY and DONE, in a 2-bit encoding.
REQ-012 In IDLE with DDATA_wen or DDATA_ren high at a rising edge, the block SHALL latch the address, wdata and op, load the counter with LATENCY-1, and go to BUSY, or to DONE directly if LATENCY=1.
REQ-013 If DDATA_wen and DDATA_ren are both high in IDLE, the request SHALL be treated as a write.
REQ-014 In BUSY, the counter SHALL decrement each cycle, and the transition to DONE SHALL occur on the edge where the counter equals 1.
REQ-015 DDATA_ready SHALL be high only in DONE, for exactly one cycle, i.e. LATENCY cycles after the accepting edge.
REQ-016 On entry to DONE, a write SHALL commit the latched wdata to array[addr[8:0]], and a read SHALL load DDATA_rdata from array[addr[8:0]].
REQ-017 DDATA_rdata SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-018 Changes to DDATA_ren, DDATA_wen, DDATA_addr or DDATA_wdata during BUSY or DONE SHALL be ignored.
REQ-019 DONE SHALL always go to IDLE; a request still asserted in the first IDLE cycle SHALL be accepted as a new request, so the initiator drops its request in the cycle after ready.
REQ-020 A read in the cycle after a write to the same line SHALL return the newly written data.
REQ-021 Address indices at or above DEPTH (when DEPTH < 512) SHALL wrap modulo DEPTH.

Reset
REQ-022 While start_i is low: state is IDLE, DDATA_ready is 0, DDATA_rdata is 0, the counter is 0, and the latched request is cleared.
REQ-023 Reset asserted in BUSY or DONE SHALL abort the request: an uncommitted write is discarded and no ready pulse follows.
REQ-024 The array contents SHALL NOT be reset; the bench preloads them hierarchically.

Configuration
REQ-025 With LINE_MEM_RESP_STATS_EN defined, the block SHALL add outputs rd_cnt and wr_cnt, each 16 bits. Each is reset to 0 and increments by 1 on each DONE of its op type, saturating at 0xFFFF.
REQ-026 Without LINE_MEM_RESP_STATS_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-027 Scenario: reset, preload array[0]=256'h5, LATENCY=10, ren with addr 0 for one cycle -> DDATA_ready high exactly 10 cycles after acceptance, for one cycle, with rdata=256'h5.
REQ-028 Scenario: wen with addr 0x23 and wdata all-0xA5, then a read of 0x23 issued the cycle after ready -> the read returns all-0xA5, and rdata is unchanged during the write.
REQ-029 Scenario: ren and wen both high with addr 7 and wdata 256'h1 -> write performed, then a read of 7 returns 256'h1.
REQ-030 Scenario: start_i low 4 cycles into a write to addr 3 with wdata 256'hF -> no ready pulse, and a later read of 3 returns the old contents.
REQ-031 Scenario: ren held high continuously with LATENCY=1 -> ready pulses every 2 cycles, and addr changes during BUSY or DONE are ignored.
REQ-032 Scenario: with LINE_MEM_RESP_STATS_EN defined, 3 reads and 2 writes -> rd_cnt=3 and wr_cnt=2; with wr_cnt forced to 0xFFFF, a further write leaves it at 0xFFFF.
